irq_pending_ctrl: RTL and testbench

- Interrupt front-end that sits directly upstream of the 16-input priority encoder (W[15:0] -> Y[3:0], Z).
- Synchronises 16 asynchronous request lines, captures edges into a sticky pending register and applies the enable mask.
- Drives the masked pending vector onto the encoder's W input and reads back Y/Z.
- Runs a request/acknowledge/end-of-interrupt handshake with the CPU, keeping a single interrupt in service at a time.

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_sync_edge.sv | 34 +++
 rtl/irq_pending_ctrl.sv | 92 +++++++++
 tb/tb_irq_pending_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and state type for the interrupt front-end
package irq_pkg;

  localparam int N_IRQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - single request line synchroniser with rising-edge detect
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  // Fills with ones after reset; the top bit says both sync and history hold post-reset samples.
  logic [SYNC_STAGES:0]   armed_q;

  // Synchroniser chain, edge-history flop and post-reset arming shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req};
      hist_q  <= sync_q[SYNC_STAGES-1];
      armed_q <= {armed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  // A line already high when reset releases is taken as its baseline level, not as an edge.
  assign rise  = level & ~hist_q & armed_q[SYNC_STAGES];

endmodule

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - pending capture, mask and CPU handshake ahead of the priority encoder
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] req_i,
  input  logic [N_IRQ-1:0] mask_i,
  output logic [N_IRQ-1:0] w_o,
  input  logic [ID_W-1:0]  y_i,
  input  logic             z_i,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             ack_i,
  input  logic             eoi_i,
  output logic             in_service_o
);

  state_t           state_q;
  logic [N_IRQ-1:0] level;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] clr;
  logic             ack_take;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req_i[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  // Only an acknowledge taken in REQ retires the presented line.
  assign ack_take = (state_q == REQ) && ack_i;
  assign clr      = ack_take ? ({{(N_IRQ-1){1'b0}}, 1'b1} << irq_id_o) : '0;

  // Sticky pending: a new edge in the same cycle as the clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

  assign pending = (EDGE_MODE != 0) ? pending_q : level;
  assign w_o     = pending & mask_i;

  // One interrupt at a time: present, wait for ack, hold in service until eoi.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irq_o        <= 1'b0;
      irq_id_o     <= '0;
      in_service_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (z_i) begin
            irq_id_o <= y_i;
            irq_o    <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (ack_i) begin
            irq_o        <= 1'b0;
            in_service_o <= 1'b1;
            state_q      <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi_i) begin
            in_service_o <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb/tb_irq_pending_ctrl.sv - randomized and directed scoreboard bench for irq_pending_ctrl
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_i = '0;
  logic [15:0] mask_i = '0;
  logic [15:0] w_o;
  logic [3:0]  y_i;
  logic        z_i;
  logic        irq_o;
  logic [3:0]  irq_id_o;
  logic        ack_i = 1'b0;
  logic        eoi_i = 1'b0;
  logic        in_service_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .mask_i(mask_i), .w_o(w_o),
    .y_i(y_i), .z_i(z_i), .irq_o(irq_o), .irq_id_o(irq_id_o),
    .ack_i(ack_i), .eoi_i(eoi_i), .in_service_o(in_service_o)
  );

  // 16-input priority encoder closing the W/Y/Z loop
  always_comb begin
    y_i = '0;
    for (int i = 0; i < 16; i++) if (w_o[i]) y_i = 4'(i);
  end
  assign z_i = |w_o;

  // Reference model: samples of req_i per edge, pending set, handshake phase
  logic [15:0] m_samples[$];
  logic [15:0] m_pend;
  int          m_phase;   // 0 idle, 1 presented, 2 in service
  logic [3:0]  m_id;
  logic        m_irq;
  logic        m_svc;
  int          exp_q[$];

  function automatic int hi_bit(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_samples.delete();
    m_pend = '0; m_phase = 0; m_id = '0; m_irq = 1'b0; m_svc = 1'b0;
    exp_q.delete();
  endtask

  // Called at each active edge with the inputs that edge sampled.
  task automatic model_step();
    logic [15:0] w;
    logic [15:0] rise;
    logic [15:0] clr;
    int n;
    int h;
    w = m_pend & mask_i;
    rise = '0;
    clr = '0;
    n = m_samples.size();
    // req seen two edges ago is high and three edges ago low; both must be post-reset samples
    if (n >= 3) rise = m_samples[n-2] & ~m_samples[n-3];
    if (m_phase == 0) begin
      h = hi_bit(w);
      if (h >= 0) begin
        m_id = h[3:0]; m_irq = 1'b1; m_phase = 1;
        exp_q.push_back(h);
      end
    end else if (m_phase == 1) begin
      if (ack_i) begin
        clr[m_id] = 1'b1; m_irq = 1'b0; m_svc = 1'b1; m_phase = 2;
      end
    end else begin
      if (eoi_i) begin
        m_svc = 1'b0; m_phase = 0;
      end
    end
    m_pend = (m_pend & ~clr) | rise;
    m_samples.push_back(req_i);
    if (m_samples.size() > 3) void'(m_samples.pop_front());
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output each cycle and pop an expected id on each new irq_o
  logic prev_irq = 1'b0;
  always @(negedge clk) begin
    int e;
    cmp("w_o", 32'(w_o), 32'(m_pend & mask_i));
    cmp("irq_o", 32'(irq_o), 32'(m_irq));
    cmp("in_service_o", 32'(in_service_o), 32'(m_svc));
    cmp("irq_id_o", 32'(irq_id_o), 32'(m_id));
    if (irq_o && !prev_irq) begin
      if (exp_q.size() == 0) begin
        cmp("unexpected_irq", 32'(irq_id_o), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        cmp("presented_id", 32'(irq_id_o), 32'(e));
      end
    end
    prev_irq = irq_o;
  end

  task automatic step(input logic [15:0] r, input logic [15:0] m, input logic a, input logic e);
    @(negedge clk);
    #2;
    req_i = r; mask_i = m; ack_i = a; eoi_i = e;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [15:0] rr;
  logic [15:0] rm;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    mask_i = 16'hFFFF;
    release_reset();
    repeat (4) step(16'h0, 16'hFFFF, 0, 0);

    // Single request on line 5
    step(16'h0020, 16'hFFFF, 0, 0);
    step(16'h0020, 16'hFFFF, 0, 0);
    step(16'h0020, 16'hFFFF, 0, 0);
    cmp("single_w", 32'(w_o), 32'h0020);
    cmp("single_irq_early", 32'(irq_o), 32'h0);
    step(16'h0020, 16'hFFFF, 0, 0);
    cmp("single_irq", 32'(irq_o), 32'h1);
    cmp("single_id", 32'(irq_id_o), 32'h5);
    step(16'h0020, 16'hFFFF, 1, 0);
    cmp("single_svc", 32'(in_service_o), 32'h1);
    cmp("single_cleared", 32'(w_o), 32'h0);
    step(16'h0020, 16'hFFFF, 0, 1);
    cmp("single_eoi", 32'(in_service_o), 32'h0);
    repeat (3) step(16'h0, 16'hFFFF, 0, 0);

    // Priority order, 12 before 3
    repeat (4) step(16'h1008, 16'hFFFF, 0, 0);
    cmp("prio_first", 32'(irq_id_o), 32'd12);
    step(16'h1008, 16'hFFFF, 1, 0);
    step(16'h1008, 16'hFFFF, 0, 1);
    cmp("prio_gap", 32'(irq_o), 32'h0);
    step(16'h1008, 16'hFFFF, 0, 0);
    cmp("prio_second_irq", 32'(irq_o), 32'h1);
    cmp("prio_second_id", 32'(irq_id_o), 32'd3);
    step(16'h1008, 16'hFFFF, 1, 0);
    step(16'h1008, 16'hFFFF, 0, 1);
    repeat (3) step(16'h0, 16'hFFFF, 0, 0);

    // Masked line retained, presented once unmasked
    repeat (4) step(16'h0080, 16'hFF7F, 0, 0);
    cmp("mask_w", 32'(w_o), 32'h0);
    cmp("mask_irq", 32'(irq_o), 32'h0);
    step(16'h0080, 16'hFFFF, 0, 0);
    cmp("unmask_w", 32'(w_o), 32'h0080);
    cmp("unmask_id", 32'(irq_id_o), 32'd7);
    step(16'h0080, 16'hFFFF, 1, 0);
    step(16'h0080, 16'hFFFF, 0, 1);
    repeat (3) step(16'h0, 16'hFFFF, 0, 0);

    // No preemption of id 2 by line 15, then stray ack in IDLE
    repeat (4) step(16'h0004, 16'hFFFF, 0, 0);
    step(16'h0004, 16'hFFFF, 1, 0);
    repeat (4) step(16'h8004, 16'hFFFF, 0, 0);
    cmp("nopre_irq", 32'(irq_o), 32'h0);
    cmp("nopre_id", 32'(irq_id_o), 32'd2);
    step(16'h8004, 16'hFFFF, 1, 1);
    cmp("stray_ack_svc", 32'(in_service_o), 32'h0);
    step(16'h8004, 16'hFFFF, 0, 0);
    cmp("after_eoi_id", 32'(irq_id_o), 32'd15);
    step(16'h8004, 16'hFFFF, 1, 0);
    step(16'h8004, 16'hFFFF, 0, 1);
    step(16'h8004, 16'hFFFF, 1, 0);
    cmp("idle_ack_irq", 32'(irq_o), 32'h0);
    cmp("idle_ack_svc", 32'(in_service_o), 32'h0);
    repeat (3) step(16'h0, 16'hFFFF, 0, 0);

    // Re-edge of line 4 lands on the ack of id 4: set wins
    step(16'h0010, 16'hFFFF, 0, 0);
    step(16'h0000, 16'hFFFF, 0, 0);
    step(16'h0010, 16'hFFFF, 0, 0);
    step(16'h0010, 16'hFFFF, 0, 0);
    cmp("coll_id", 32'(irq_id_o), 32'd4);
    step(16'h0010, 16'hFFFF, 1, 0);
    cmp("coll_pending", 32'(w_o), 32'h0010);
    step(16'h0010, 16'hFFFF, 0, 1);
    step(16'h0010, 16'hFFFF, 0, 0);
    cmp("coll_represent", 32'(irq_o), 32'h1);
    cmp("coll_repid", 32'(irq_id_o), 32'd4);
    step(16'h0010, 16'hFFFF, 1, 0);
    step(16'h0010, 16'hFFFF, 0, 1);

    // Randomized traffic with random masks and handshakes
    rr = 16'h0010;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) rr = rr ^ (16'h1 << $urandom_range(0, 15));
      rm = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFFFF;
      step(rr, rm, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    // Reset in flight with all lines high, then release without new edges
    repeat (6) step(16'hFFFF, 16'hFFFF, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("rst_w", 32'(w_o), 32'h0);
    cmp("rst_irq", 32'(irq_o), 32'h0);
    cmp("rst_id", 32'(irq_id_o), 32'h0);
    cmp("rst_svc", 32'(in_service_o), 32'h0);
    release_reset();
    repeat (10) step(16'hFFFF, 16'hFFFF, 0, 0);
    cmp("post_rst_w", 32'(w_o), 32'h0);
    cmp("post_rst_irq", 32'(irq_o), 32'h0);
    step(16'h0000, 16'hFFFF, 0, 0);
    cmp("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
